neuron_mac_accumulator: RTL and testbench

//  Downstream of the pixel RegisterFile / weights_memory read path. Consumes one 24-bit pixel word
//  (3 x 8-bit channels) plus its three signed weights per beat. Accumulates the dot product over one

---
 rtl/neuron_mac_accumulator.sv | 111 +++++++++++
 tb/tb_neuron_mac_accumulator.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_accumulator.sv
// Frame-level dot-product engine: 3-channel pixel x signed weight MAC with a
// two-stage product/sum pipeline, bias add and a registered cat / not-cat decision.
`timescale 1ns/1ps
module neuron_mac_accumulator #(
  parameter int Amba_Word        = 24,
  parameter int Amba_Addr_Depth  = 12,
  parameter int Weight_precision = 5,
  parameter int ACC_WIDTH        = 28,
  parameter logic signed [ACC_WIDTH-1:0] BIAS = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic                          in_last,
  input  logic [Amba_Word-1:0]          pixels,
  input  logic [3*Weight_precision-1:0] weights,
  output logic                          busy,
  output logic                          result_valid,
  output logic                          cat_out,
  output logic [ACC_WIDTH-1:0]          score
);

  localparam int PIX_W     = Amba_Word / 3;
  localparam int PROD_W    = PIX_W + 1 + Weight_precision;
  localparam int SUM_W     = PROD_W + 2;
  localparam int MAX_BEATS = (1 << Amba_Addr_Depth) - 1;
  localparam logic [Amba_Addr_Depth-1:0] LAST_CNT = Amba_Addr_Depth'(MAX_BEATS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DECIDE} state_t;

  state_t                       state_q, state_d;
  logic                         drain_cnt_q;
  logic [Amba_Addr_Depth-1:0]   beat_cnt_q;
  logic                         s1_valid_q, s2_valid_q;
  logic signed [PROD_W-1:0]     prod_d [3];
  logic signed [PROD_W-1:0]     prod_q [3];
  logic signed [SUM_W-1:0]      sum_d, sum_q;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_bias;
  logic                         result_valid_q, cat_q;
  logic [ACC_WIDTH-1:0]         score_q;
  logic                         beat_fire, frame_end, clear;

  assign beat_fire = (state_q == ACCUM) && in_valid;
  assign frame_end = beat_fire && (in_last || (beat_cnt_q == LAST_CNT));
  assign clear     = (state_q == IDLE) && start;
  assign acc_bias  = acc_q + BIAS;

  // Pixel channels are unsigned, so a zero MSB is prepended before the signed multiply.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      prod_d[k] = PROD_W'($signed({1'b0, pixels[PIX_W*k +: PIX_W]}))
                * PROD_W'($signed(weights[Weight_precision*k +: Weight_precision]));
    end
    sum_d = SUM_W'(prod_q[0]) + SUM_W'(prod_q[1]) + SUM_W'(prod_q[2]);
  end

  // NOTE: next state gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (frame_end) state_d = DRAIN;
      DRAIN:   if (drain_cnt_q) state_d = DECIDE;
      DECIDE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      drain_cnt_q    <= 1'b0;
      beat_cnt_q     <= '0;
      s1_valid_q     <= 1'b0;
      s2_valid_q     <= 1'b0;
      for (int k = 0; k < 3; k++) prod_q[k] <= '0;
      sum_q          <= '0;
      acc_q          <= '0;
      result_valid_q <= 1'b0;
      cat_q          <= 1'b0;
      score_q        <= '0;
    end else begin
      state_q        <= state_d;
      drain_cnt_q    <= (state_q == DRAIN) ? ~drain_cnt_q : 1'b0;
      s1_valid_q     <= beat_fire;
      s2_valid_q     <= clear ? 1'b0 : s1_valid_q;
      for (int k = 0; k < 3; k++) prod_q[k] <= prod_d[k];
      sum_q          <= sum_d;
      result_valid_q <= (state_q == DECIDE);

      if (clear)          beat_cnt_q <= '0;
      else if (beat_fire) beat_cnt_q <= beat_cnt_q + 1'b1;

      if (clear)           acc_q <= '0;
      else if (s2_valid_q) acc_q <= acc_q + ACC_WIDTH'(sum_q);

      // Strictly positive is a cat; a zero score is not.
      if (state_q == DECIDE) begin
        score_q <= acc_bias;
        cat_q   <= !acc_bias[ACC_WIDTH-1] && (acc_bias != '0);
      end
    end
  end

  assign busy         = (state_q != IDLE);
  assign result_valid = result_valid_q;
  assign cat_out      = cat_q;
  assign score        = score_q;

endmodule

// File: tb/tb_neuron_mac_accumulator.sv
// Directed bench for neuron_mac_accumulator: hand-computed frame scores, latency,
// forced-last, mid-frame reset and start-pulse corner cases.
`timescale 1ns/1ps
module tb_neuron_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_last;
  logic [23:0] pixels;
  logic [14:0] weights;
  logic        busy, result_valid, cat_out;
  logic [27:0] score;

  int n_vec = 0;
  int n_err = 0;
  int lat;
  int extra;

  always #5 clk = ~clk;

  neuron_mac_accumulator dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .pixels       (pixels),
    .weights      (weights),
    .busy         (busy),
    .result_valid (result_valid),
    .cat_out      (cat_out),
    .score        (score)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [23:0] p, input logic [14:0] w, input logic last);
    pixels   = p;
    weights  = w;
    in_valid = 1'b1;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Edges counted from the last-beat edge until result_valid is seen; -1 on timeout.
  task automatic wait_result(output int l);
    l = -1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (result_valid === 1'b1) begin
        l = i;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    pixels = '0; weights = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy",   busy,         0);
    check("reset_rvalid", result_valid, 0);
    check("reset_cat",    cat_out,      0);
    check("reset_score",  $signed(score), 0);
    rst = 1'b0;
    tick();

    // Single beat, +1 weights: 3*10 = 30.
    start_frame();
    check("t1_busy", busy, 1);
    beat(24'h0A0A0A, 15'h0421, 1'b1);
    wait_result(lat);
    check("t1_latency", lat, 3);
    check("t1_score",   $signed(score), 30);
    check("t1_cat",     cat_out, 1);
    check("t1_busy_done", busy, 0);
    tick();
    check("t1_rvalid_drop", result_valid, 0);
    check("t1_cat_hold",    cat_out, 1);

    // Single beat, -1 weights on full-scale pixels: -765.
    start_frame();
    beat(24'hFFFFFF, 15'h7FFF, 1'b1);
    wait_result(lat);
    check("t2_latency", lat, 3);
    check("t2_score",   $signed(score), -765);
    check("t2_cat",     cat_out, 0);
    tick();

    // start with in_valid in IDLE drops that beat; starts in ACCUM/DRAIN/DECIDE ignored.
    start = 1'b1; in_valid = 1'b1; in_last = 1'b0;
    pixels = 24'h0A0A0A; weights = 15'h0421;
    tick();
    pixels = 24'h010101;
    tick();
    pixels = 24'h020202; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    repeat (3) tick();
    start = 1'b0;
    check("t6_rvalid", result_valid, 1);
    check("t6_score",  $signed(score), 9);
    check("t6_cat",    cat_out, 1);
    tick();
    check("t6_no_restart", busy, 0);
    check("t6_rvalid_drop", result_valid, 0);

    // start right after result_valid is accepted; 5 - 5 = 0 is not a cat.
    start_frame();
    check("t3_busy", busy, 1);
    beat(24'h000005, 15'h0001, 1'b0);
    beat(24'h000005, 15'h001F, 1'b1);
    wait_result(lat);
    check("t3_latency", lat, 3);
    check("t3_score",   $signed(score), 0);
    check("t3_cat",     cat_out, 0);
    tick();

    // No in_last: forced last on beat 4095; 4095 * 3 * 255 * -16 = -50,122,800.
    start_frame();
    pixels = 24'hFFFFFF; weights = 15'h4210; in_valid = 1'b1; in_last = 1'b0;
    repeat (4094) tick();
    check("t4_busy_pre",   busy, 1);
    check("t4_rvalid_pre", result_valid, 0);
    tick();
    in_valid = 1'b0;
    wait_result(lat);
    check("t4_latency", lat, 3);
    check("t4_score",   $signed(score), -50122800);
    check("t4_cat",     cat_out, 0);
    check("t4_busy_done", busy, 0);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (result_valid !== 1'b0) extra++;
    end
    check("t4_single_pulse", extra, 0);

    // Reset mid-ACCUM abandons the frame immediately.
    start_frame();
    beat(24'hFFFFFF, 15'h0421, 1'b0);
    beat(24'hFFFFFF, 15'h0421, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_busy",   busy, 0);
    check("t5_rst_rvalid", result_valid, 0);
    check("t5_rst_cat",    cat_out, 0);
    check("t5_rst_score",  $signed(score), 0);
    #3 rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (result_valid !== 1'b0) extra++;
    end
    check("t5_no_result", extra, 0);
    start_frame();
    beat(24'h010101, 15'h0421, 1'b1);
    wait_result(lat);
    check("t5_latency", lat, 3);
    check("t5_score",   $signed(score), 3);
    check("t5_cat",     cat_out, 1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
